perf_cnt_axil_slave: RTL
========================

PERF_CNT_AXIL_SLAVE -- requirements
Module: perf_cnt_axil_slave

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, width of araddr/awaddr; only bits [11:0] are decoded.
REQ-002 cpu_clk  in  1  sole clock; all logic rising-edge.
REQ-003 cpu_reset  in  1  asynchronous, active-high reset.
REQ-004 cpu_perf_cnt  in  512  16 live counters; counter i at [32i+31:32i].
REQ-005 cpu_perf_cnt_araddr  in  ADDR_WIDTH  read address.
REQ-006 cpu_perf_cnt_arvalid / cpu_perf_cnt_arready  in / out  1  AR handshake.
REQ-007 cpu_perf_cnt_rdata  out  32  read data.
REQ-008 cpu_perf_cnt_rresp  out  2  read response.
REQ-009 cpu_perf_cnt_rvalid / cpu_perf_cnt_rready  out / in  1  R handshake.
REQ-010 cpu_perf_cnt_awaddr  in  ADDR_WIDTH  write address (value ignored).
REQ-011 cpu_perf_cnt_awvalid / cpu_perf_cnt_awready  in / out  1  AW handshake.
REQ-012 cpu_perf_cnt_wdata / cpu_perf_cnt_wstrb  in  32 / 4  write data/strobe (ignored).
REQ-013 cpu_perf_cnt_wvalid / cpu_perf_cnt_wready  in / out  1  W handshake.
REQ-014 cpu_perf_cnt_bresp  out  2  write response.
REQ-015 cpu_perf_cnt_bvalid / cpu_perf_cnt_bready  out / in  1  B handshake.

Function
REQ-016 Block is an AXI4-Lite slave exposing 16 read-only 32-bit counters at offsets 0x000-0x03C; index = araddr[5:2]; araddr[1:0] ignored.
REQ-017 Read FSM states R_IDLE, R_DATA; R_IDLE drives arready=1, rvalid=0.
REQ-018 AR handshake (arvalid & arready) in R_IDLE -> R_DATA next cycle with rvalid=1, rdata/rresp registered from values at handshake edge; latency exactly 1 cycle.
REQ-019 R_DATA: arready=0; rvalid, rdata, rresp held stable until rvalid & rready, then R_IDLE next cycle (no back-to-back AR acceptance in the R handshake cycle).
REQ-020 Offset in range (araddr[11:6]==0): rresp=2'b00; otherwise rdata=0, rresp=2'b10 (SLVERR).
REQ-021 Write FSM states W_IDLE, W_RESP with aw_got/w_got flags; awready=~aw_got in W_IDLE, wready=~w_got in W_IDLE; both 0 in W_RESP.
REQ-022 AW and W accepted in either order or same cycle; when both flags set (including same-cycle acceptance) -> W_RESP next cycle, bvalid=1, bresp=2'b10, flags cleared.
REQ-023 W_RESP holds bvalid until bvalid & bready, then W_IDLE next cycle; writes never change any state other than the write FSM.
REQ-024 Read and write channels are fully independent; simultaneous AR and AW/W handshakes in one cycle are both accepted.
REQ-025 Counter inputs are sampled, never modified; no wrap handling needed (values passed through as-is).

Reset
REQ-026 cpu_reset asserted asynchronously forces R_IDLE, W_IDLE, flags 0, rvalid=0, bvalid=0, rdata=0, rresp=2'b00, bresp=2'b00, shadow registers 0.
REQ-027 After deassertion arready=1, awready=1, wready=1 on the first clock edge; in-flight transactions are dropped without response.

Configuration
REQ-028 Macro PERF_CNT_SNAPSHOT_EN defined: a read of offset 0x000 returns live counter 0 and, on the same AR handshake edge, copies all 16 counters into shadow registers; reads of 0x004-0x03C return shadow values.
REQ-029 PERF_CNT_SNAPSHOT_EN undefined: no shadow registers; every offset returns the live counter sampled at AR handshake.

Verification
REQ-030 Reset then cnt[3]=0x1234_5678, read 0x00C with rready=1 -> rvalid 1 cycle after AR handshake, rdata=0x1234_5678, rresp=00.
REQ-031 Read 0x040 -> rdata=0, rresp=10; read 0xFFC -> rresp=10.
REQ-032 rready held 0 for 5 cycles during R_DATA while counters change -> rdata stable, arready=0 throughout, R completes when rready=1.
REQ-033 W before AW (2-cycle gap), then AW; bready=0 for 3 cycles -> single bvalid with bresp=10 held until bready, no second response.
REQ-034 With PERF_CNT_SNAPSHOT_EN: read 0x000 when cnt[5]=100, set cnt[5]=200, read 0x014 -> 100; without macro -> 200.
REQ-035 Assert cpu_reset mid-R_DATA and mid-W_RESP -> rvalid and bvalid drop to 0 immediately, readies 1 after release.

Source files
------------

// File: rtl/perf_cnt_axil_slave.sv
// AXI4-Lite read-only window onto 16 live 32-bit performance counters (offsets 0x000-0x03C).
// Optional macro PERF_CNT_SNAPSHOT_EN: reading 0x000 snapshots all counters for coherent follow-up reads.
module perf_cnt_axil_slave #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_reset,
    input  logic [511:0]          cpu_perf_cnt,
    input  logic [ADDR_WIDTH-1:0] cpu_perf_cnt_araddr,
    input  logic                  cpu_perf_cnt_arvalid,
    output logic                  cpu_perf_cnt_arready,
    output logic [31:0]           cpu_perf_cnt_rdata,
    output logic [1:0]            cpu_perf_cnt_rresp,
    output logic                  cpu_perf_cnt_rvalid,
    input  logic                  cpu_perf_cnt_rready,
    input  logic [ADDR_WIDTH-1:0] cpu_perf_cnt_awaddr,
    input  logic                  cpu_perf_cnt_awvalid,
    output logic                  cpu_perf_cnt_awready,
    input  logic [31:0]           cpu_perf_cnt_wdata,
    input  logic [3:0]            cpu_perf_cnt_wstrb,
    input  logic                  cpu_perf_cnt_wvalid,
    output logic                  cpu_perf_cnt_wready,
    output logic [1:0]            cpu_perf_cnt_bresp,
    output logic                  cpu_perf_cnt_bvalid,
    input  logic                  cpu_perf_cnt_bready
);

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;

    logic [0:0]  r_state_q, r_state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [0:0]  w_state_q, w_state_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        ar_hs_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic [3:0]  rd_idx_s;
    logic        in_range_s;
    logic [31:0] live_word_s;
    logic [31:0] read_word_s;
    logic        unused_ok_s;

    assign cpu_perf_cnt_arready = (r_state_q == R_IDLE);
    assign cpu_perf_cnt_rvalid  = (r_state_q == R_DATA);
    assign cpu_perf_cnt_rdata   = rdata_q;
    assign cpu_perf_cnt_rresp   = rresp_q;
    assign cpu_perf_cnt_awready = (w_state_q == W_IDLE) & ~aw_got_q;
    assign cpu_perf_cnt_wready  = (w_state_q == W_IDLE) & ~w_got_q;
    assign cpu_perf_cnt_bvalid  = (w_state_q == W_RESP);
    assign cpu_perf_cnt_bresp   = bresp_q;

    assign ar_hs_s     = cpu_perf_cnt_arvalid & cpu_perf_cnt_arready;
    assign aw_hs_s     = cpu_perf_cnt_awvalid & cpu_perf_cnt_awready;
    assign w_hs_s      = cpu_perf_cnt_wvalid & cpu_perf_cnt_wready;
    assign rd_idx_s    = cpu_perf_cnt_araddr[5:2];
    assign in_range_s  = (cpu_perf_cnt_araddr[11:6] == 6'd0);
    assign live_word_s = cpu_perf_cnt[{rd_idx_s, 5'b00000} +: 32];

    // Address bits outside [11:2] and all write payload are deliberately ignored.
    assign unused_ok_s = ^{cpu_perf_cnt_awaddr, cpu_perf_cnt_wdata, cpu_perf_cnt_wstrb,
                           cpu_perf_cnt_araddr[ADDR_WIDTH-1:12], cpu_perf_cnt_araddr[1:0]};

`ifdef PERF_CNT_SNAPSHOT_EN
    logic [511:0] shadow_q, shadow_d;
    logic         snap_s;

    assign snap_s      = ar_hs_s & in_range_s & (rd_idx_s == 4'd0);
    assign read_word_s = (rd_idx_s == 4'd0) ? live_word_s : shadow_q[{rd_idx_s, 5'b00000} +: 32];

    // Shadow copy is taken on the same edge that accepts a read of offset 0x000.
    always_comb begin
        shadow_d = shadow_q;
        if (snap_s) begin
            shadow_d = cpu_perf_cnt;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Shadow register bank.
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            shadow_q <= 512'd0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    assign read_word_s = live_word_s;
`endif

    // Read channel: accept AR in R_IDLE, hold the registered response until R handshake.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (cpu_perf_cnt_arvalid) begin
                    r_state_d = R_DATA;
                    if (in_range_s) begin
                        rdata_d = read_word_s;
                        rresp_d = 2'b00;
                    end else begin
                        rdata_d = 32'd0;
                        rresp_d = 2'b10;
                    end
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (cpu_perf_cnt_rready) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Write channel: collect AW and W in any order, then answer once with SLVERR.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if ((aw_got_q | aw_hs_s) & (w_got_q | w_hs_s)) begin
                    w_state_d = W_RESP;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    bresp_d   = 2'b10;
                end else begin
                    aw_got_d = aw_got_q | aw_hs_s;
                    w_got_d  = w_got_q | w_hs_s;
                end
            end
            W_RESP: begin
                if (cpu_perf_cnt_bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                aw_got_d  = 1'b0;
                w_got_d   = 1'b0;
            end
        endcase
    end

    // State and response registers for both channels.
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            r_state_q <= R_IDLE;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            bresp_q   <= bresp_d;
        end
    end

endmodule
